adsr_envelope_vca: RTL
======================

// Module: adsr_envelope_vca
// PURPOSE
//  Downstream stage of the NCO. Applies an ADSR amplitude envelope, driven by a note gate, to the NCO sample stream.
//  Input samples are unsigned offset-binary, with midscale meaning silence.
//  Output is in the same format, scaled about midscale, and feeds the DAC/PWM output stage.
//  All logic runs on the system clock and advances only on the sample-rate strobe.
// PARAMETERS
//  BIT_DEPTH   8   sample width; also the width of the envelope gain applied to samples
//  ENV_WIDTH   16  envelope accumulator width; must be > BIT_DEPTH
// PORTS
//  clk            in   1          system clock
//  reset          in   1          asynchronous, active-high
//  sample_en      in   1          one-clk strobe per sample period (same strobe that advances the NCO)
//  sample_in      in   BIT_DEPTH  NCO output, offset-binary
//  gate           in   1          note on (1) / note off (0); level-sensitive
//  attack_inc     in   ENV_WIDTH  envelope increment per tick in ATTACK; 0 = instant
//  decay_dec      in   ENV_WIDTH  envelope decrement per tick in DECAY; 0 = instant
//  sustain_level  in   BIT_DEPTH  sustain target; full target = {sustain_level, zeros}
//  release_dec    in   ENV_WIDTH  envelope decrement per tick in RELEASE; 0 = instant
//  sample_out     out  BIT_DEPTH  enveloped sample, offset-binary
//  out_valid      out  1          one-clk pulse each time sample_out updates
//  env_level      out  BIT_DEPTH  env[ENV_WIDTH-1 -: BIT_DEPTH]; current gain
//  env_state      out  3          current FSM state
//  active         out  1          1 when env_state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, env=0, sample_out=2**(BIT_DEPTH-1), out_valid=0, env_level=0, active=0.
//  - Reset mid-note: aborts immediately, with no release.
//  Tick definition: clk edge with sample_en=1. FSM, gate sampling and env update happen only on ticks.
//  - Between ticks, all state and outputs hold, except out_valid, which returns to 0.
//  gate is sampled on ticks. Edges are detected against the previous tick's sample.
//  FSM states: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
//  - IDLE: gate=1 -> ATTACK; env stays 0 on this tick.
//  - ATTACK: env += attack_inc, saturating at 2**ENV_WIDTH-1.
//    Reaching max, or attack_inc=0 (env set to max) -> DECAY.
//  - DECAY: env -= decay_dec, clamped at S = {sustain_level, 0}.
//    Reaching S, or decay_dec=0 -> SUSTAIN with env=S. If env<=S on entry, env=S and -> SUSTAIN.
//  - SUSTAIN: env = S every tick, so sustain_level changes are tracked immediately.
//  - RELEASE: env -= release_dec, clamped at 0. Reaching 0, or release_dec=0 -> IDLE.
//  - Gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE on the same tick. No env step in the other state that tick.
//  - Gate 0->1 in RELEASE -> ATTACK, retriggering from the current env (no jump to 0).
//  - Gate held 1 through IDLE->ATTACK needs no new edge; the level is enough.
//  - Rate inputs are read on every tick and may change at any time.
//  VCA arithmetic, on each tick using sample_in and env_level BEFORE this tick's env update:
//  - s = $signed({1'b0,sample_in}) - 2**(BIT_DEPTH-1), (BIT_DEPTH+1)-bit signed.
//  - p = s * $signed({1'b0,env_level}), 2*BIT_DEPTH+1 bits.
//  - sample_out <= (p >>> BIT_DEPTH) + 2**(BIT_DEPTH-1), truncated to BIT_DEPTH. No overflow is possible.
//  - Latency: sample_out and out_valid are registered on the tick edge, visible 1 clk after sample_en.
//  - env_level/env_state reflect the post-update values on the same edge.
//  sample_en held high continuously is legal: every clk is a tick (CLK_FREQ == SAMPLE_RATE case).
// STRUCTURE
//  Shared header: state encodings ENV_IDLE..ENV_RELEASE (3-bit) beside the waveform defines, for NCO-side monitors.
//  Sub-module envelope_vca: pure registered multiply stage (sample_in, gain, sample_en -> sample_out, out_valid).
//  The FSM and accumulator stay in the top module.
// TESTING (BIT_DEPTH=8, ENV_WIDTH=16, sample_en every 4 clks)
//  1. Reset, no gate, sample_in=0xFF -> sample_out=0x80 on every tick, env_state=0, active=0.
//  2. Attack/decay: gate=1, attack_inc=0x4000, decay_dec=0x1000, sustain_level=0x80.
//     -> ATTACK on tick 1; env 0x4000, 0x8000, 0xC000, 0xFFFF (saturated) -> DECAY.
//     -> 8 decay ticks, env clamps to 0x8000 -> SUSTAIN.
//  3. VCA with env_level=0xFF: sample_in=0xFF -> 0xFE; sample_in=0x00 -> 0x00; sample_in=0x80 -> 0x80.
//     With env_level=0x80: sample_in=0xFF -> 0xBF.
//  4. Release and retrigger: from SUSTAIN (0x8000), gate=0, release_dec=0x2000 -> RELEASE, env 0x6000, 0x4000.
//     Gate=1 -> ATTACK from 0x4000, not 0. Gate=0 again, release to 0 -> IDLE, active=0.
//  5. Zero rates: attack_inc=decay_dec=0, sustain 0x40 -> ATTACK->DECAY->SUSTAIN on consecutive ticks with env 0xFFFF, 0x4000, 0x4000.
//     Release_dec=0 -> env 0 and IDLE in one tick.
//  6. Assert reset mid-ATTACK between ticks -> all outputs at reset values immediately.
//     No out_valid until the next tick after release of reset.

Source files
------------

// File: rtl/adsr_envelope_vca_pkg.sv
// Shared definitions for the NCO -> envelope/VCA signal chain.
// NCO waveform selects and envelope state encodings live side by side so that
// NCO-side monitors can decode both without pulling in either RTL module.
package adsr_envelope_vca_pkg;

    // NCO waveform selects
    localparam logic [1:0] WAVE_SAW      = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_SINE     = 2'd3;

    // Envelope FSM state encodings (3-bit, visible on env_state)
    localparam logic [2:0] ENV_IDLE    = 3'd0;
    localparam logic [2:0] ENV_ATTACK  = 3'd1;
    localparam logic [2:0] ENV_DECAY   = 3'd2;
    localparam logic [2:0] ENV_SUSTAIN = 3'd3;
    localparam logic [2:0] ENV_RELEASE = 3'd4;

    // Rising edge of a level signal against its previous sampled value
    function automatic logic rise_edge(input logic level, input logic level_prev);
        return level & ~level_prev;
    endfunction

endpackage

// File: rtl/adsr_envelope_vca_envelope_vca.sv
// Registered VCA stage: scales an offset-binary sample about midscale by an
// unsigned gain. Output and its valid pulse update only on sample strobes.
module envelope_vca #(
    parameter int BIT_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [BIT_DEPTH-1:0] sample_in,
    input  logic [BIT_DEPTH-1:0] gain,
    output logic [BIT_DEPTH-1:0] sample_out,
    output logic                 out_valid
);

    localparam logic [BIT_DEPTH-1:0] MIDSCALE = {1'b1, {(BIT_DEPTH-1){1'b0}}};

    logic signed [BIT_DEPTH:0]     centred;
    logic signed [2*BIT_DEPTH:0]   centred_x;
    logic signed [2*BIT_DEPTH:0]   gain_x;
    logic signed [2*BIT_DEPTH:0]   product;
    logic        [BIT_DEPTH-1:0]   sample_out_d;
    logic        [BIT_DEPTH-1:0]   sample_out_q;
    logic                          out_valid_q;

    // Remove the midscale offset so silence sits at zero.
    assign centred   = $signed({1'b0, sample_in}) - $signed({1'b0, MIDSCALE});

    // Both operands widened to the full product width: the gain is unsigned,
    // so the true product always fits in 2*BIT_DEPTH+1 signed bits.
    assign centred_x = {{BIT_DEPTH{centred[BIT_DEPTH]}}, centred};
    assign gain_x    = {{(BIT_DEPTH+1){1'b0}}, gain};
    assign product   = centred_x * gain_x;

    // Arithmetic shift floors toward -inf; re-adding midscale cannot overflow
    // because |product >>> BIT_DEPTH| never exceeds 2**(BIT_DEPTH-1).
    assign sample_out_d = BIT_DEPTH'(product >>> BIT_DEPTH) + MIDSCALE;

    // Capture the scaled sample on each strobe; valid pulses only on strobes.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out_q <= MIDSCALE;
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q <= sample_en;
            if (sample_en) begin
                sample_out_q <= sample_out_d;
            end
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: rtl/adsr_envelope_vca.sv
// ADSR amplitude envelope driven by a level-sensitive note gate, applied to
// the NCO sample stream through a registered VCA. All state advances only on
// sample-rate strobes; the envelope accumulator is wider than the gain so slow
// rates still make progress.
module adsr_envelope_vca
    import adsr_envelope_vca_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int ENV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [BIT_DEPTH-1:0] sample_in,
    input  logic                 gate,
    input  logic [ENV_WIDTH-1:0] attack_inc,
    input  logic [ENV_WIDTH-1:0] decay_dec,
    input  logic [BIT_DEPTH-1:0] sustain_level,
    input  logic [ENV_WIDTH-1:0] release_dec,
    output logic [BIT_DEPTH-1:0] sample_out,
    output logic                 out_valid,
    output logic [BIT_DEPTH-1:0] env_level,
    output logic [2:0]           env_state,
    output logic                 active
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    logic [2:0]           state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic                 gate_prev_q;

    logic [ENV_WIDTH-1:0] sustain_target;
    logic [ENV_WIDTH:0]   attack_sum;
    logic [ENV_WIDTH:0]   decay_diff;
    logic [ENV_WIDTH:0]   release_diff;
    logic                 attack_done;
    logic                 decay_done;
    logic                 release_done;
    logic                 gate_rise;

    // Sustain target: sustain_level occupies the gain bits, fraction is zero.
    assign sustain_target = {sustain_level, {(ENV_WIDTH-BIT_DEPTH){1'b0}}};

    // One extra bit on each step captures carry (saturate) or borrow (clamp).
    assign attack_sum   = {1'b0, env_q} + {1'b0, attack_inc};
    assign decay_diff   = {1'b0, env_q} - {1'b0, decay_dec};
    assign release_diff = {1'b0, env_q} - {1'b0, release_dec};

    // Phase completion: a zero rate means "jump straight to the target".
    // A decay that starts at or below the target also completes at once,
    // since env - dec is then already <= target (or borrows).
    assign attack_done  = (attack_inc == '0) || attack_sum[ENV_WIDTH] ||
                          (attack_sum[ENV_WIDTH-1:0] == ENV_MAX);
    assign decay_done   = (decay_dec == '0) || decay_diff[ENV_WIDTH] ||
                          (decay_diff[ENV_WIDTH-1:0] <= sustain_target);
    assign release_done = (release_dec == '0) || release_diff[ENV_WIDTH] ||
                          (release_diff[ENV_WIDTH-1:0] == '0);

    // Retrigger only on a fresh note-on seen across two consecutive ticks.
    assign gate_rise = rise_edge(gate, gate_prev_q);

    // Envelope next-state: gate release preempts any envelope step.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            ENV_IDLE: begin
                if (gate) begin
                    state_d = ENV_ATTACK;
                end
            end
            ENV_ATTACK: begin
                if (!gate) begin
                    state_d = ENV_RELEASE;
                end else if (attack_done) begin
                    env_d   = ENV_MAX;
                    state_d = ENV_DECAY;
                end else begin
                    env_d = attack_sum[ENV_WIDTH-1:0];
                end
            end
            ENV_DECAY: begin
                if (!gate) begin
                    state_d = ENV_RELEASE;
                end else if (decay_done) begin
                    env_d   = sustain_target;
                    state_d = ENV_SUSTAIN;
                end else begin
                    env_d = decay_diff[ENV_WIDTH-1:0];
                end
            end
            ENV_SUSTAIN: begin
                if (!gate) begin
                    state_d = ENV_RELEASE;
                end else begin
                    env_d = sustain_target;
                end
            end
            ENV_RELEASE: begin
                if (gate_rise) begin
                    state_d = ENV_ATTACK;
                end else if (release_done) begin
                    env_d   = '0;
                    state_d = ENV_IDLE;
                end else begin
                    env_d = release_diff[ENV_WIDTH-1:0];
                end
            end
            default: begin
                env_d   = '0;
                state_d = ENV_IDLE;
            end
        endcase
    end

    // Envelope registers advance only on ticks; reset aborts a note with no release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ENV_IDLE;
            env_q       <= '0;
            gate_prev_q <= 1'b0;
        end else if (sample_en) begin
            state_q     <= state_d;
            env_q       <= env_d;
            gate_prev_q <= gate;
        end
    end

    // Gain presented to the VCA is the pre-update envelope of this tick.
    assign env_level = env_q[ENV_WIDTH-1 -: BIT_DEPTH];
    assign env_state = state_q;
    assign active    = (state_q != ENV_IDLE);

    envelope_vca #(
        .BIT_DEPTH (BIT_DEPTH)
    ) u_vca (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .sample_in  (sample_in),
        .gain       (env_level),
        .sample_out (sample_out),
        .out_valid  (out_valid)
    );

endmodule
